// File: rtl/sb_1237_color_sequencer_pkg.sv
// Shared encodings for the TCS3200 colour sequencer: filter selects, result colours, FSM states.
// The bench imports this package as well as the RTL.
package sb_1237_color_sequencer_pkg;

   localparam int CNT_W = 14;

   // {S2,S3} as wired to the sensor
   typedef enum logic [1:0] {
      FLT_RED   = 2'b00,
      FLT_BLUE  = 2'b01,
      FLT_CLEAR = 2'b10,
      FLT_GREEN = 2'b11
   } filter_e;

   typedef enum logic [1:0] {
      COL_NONE  = 2'b00,
      COL_RED   = 2'b01,
      COL_GREEN = 2'b10,
      COL_BLUE  = 2'b11
   } color_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_DECIDE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   typedef struct packed {
      color_e color;
      logic   meas_err;
   } result_t;

   // Scan order is RED, GREEN, BLUE, CLEAR; CLEAR is terminal.
   function automatic filter_e next_filter(input filter_e f);
      case (f)
         FLT_RED:   return FLT_GREEN;
         FLT_GREEN: return FLT_BLUE;
         default:   return FLT_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/sb_1237_color_sequencer_if.sv
// Control/result bundle between a host and the colour sequencer.
// The sequencer is the slave; the host (or bench) is the master.
interface sb_1237_color_sequencer_if;
   import sb_1237_color_sequencer_pkg::*;

   logic             start;
   logic             continuous;
   logic [CNT_W-1:0] count;
   filter_e          filter_sel;
   logic             busy;
   logic             done;
   color_e           color;
   logic             meas_err;

   modport slave (
      input  start, continuous, count,
      output filter_sel, busy, done, color, meas_err
   );

   modport master (
      output start, continuous, count,
      input  filter_sel, busy, done, color, meas_err
   );

endinterface

// File: rtl/sb_1237_dwell_timer.sv
// Down-counting dwell timer: load arms it with CYCLES, expire pulses on the last enabled cycle,
// so an enabled window that starts right after load lasts exactly CYCLES cycles.
module sb_1237_dwell_timer #(
   parameter int  CYCLES = 50000,
   localparam int W     = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= W'(CYCLES);
      else if (en && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/sb_1237_color_sequencer.sv
// TCS3200 RGB scan sequencer: dwell on each filter, sample the pulse width, then pick the
// strongest channel (smallest count), flagging dark targets and dead samples.
module sb_1237_color_sequencer
   import sb_1237_color_sequencer_pkg::*;
#(
   parameter int               SETTLE_CYCLES = 50000,
   parameter logic [CNT_W-1:0] DARK_THRESH   = 14'd1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   sb_1237_color_sequencer_if.slave  bus
);

   state_e                      state, state_nxt;
   filter_e                     flt, flt_nxt;
   logic [3:0][CNT_W-1:0]       samp;
   logic                        smp_we;
   logic                        tmr_load, tmr_en, tmr_expire;
   result_t                     res, res_nxt;
   logic [CNT_W-1:0]            r_cnt, g_cnt, b_cnt, c_cnt;

   sb_1237_dwell_timer #(.CYCLES(SETTLE_CYCLES)) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         flt   <= FLT_CLEAR;
      end else begin
         state <= state_nxt;
         flt   <= flt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      flt_nxt   = flt;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      smp_we    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_SETTLE;
               flt_nxt   = FLT_RED;
               tmr_load  = 1'b1;
            end
         end
         ST_SETTLE: begin
            tmr_en = 1'b1;
            if (tmr_expire)
               state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            smp_we = 1'b1;
            if (flt == FLT_CLEAR) begin
               state_nxt = ST_DECIDE;
            end else begin
               state_nxt = ST_SETTLE;
               flt_nxt   = next_filter(flt);
               tmr_load  = 1'b1;
            end
         end
         ST_DECIDE: state_nxt = ST_DONE;
         ST_DONE: begin
            // continuous re-arms straight from DONE so busy never drops between scans
            if (bus.continuous) begin
               state_nxt = ST_SETTLE;
               flt_nxt   = FLT_RED;
               tmr_load  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               flt_nxt   = FLT_CLEAR;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            flt_nxt   = FLT_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         samp <= '0;
      else if (smp_we)
         samp[flt] <= bus.count;
   end

   assign r_cnt = samp[FLT_RED];
   assign g_cnt = samp[FLT_GREEN];
   assign b_cnt = samp[FLT_BLUE];
   assign c_cnt = samp[FLT_CLEAR];

   // Smaller pulse width = brighter channel; <= comparisons give RED > GREEN > BLUE on ties.
   always_comb begin
      res_nxt.color    = COL_NONE;
      res_nxt.meas_err = 1'b0;
      if ((r_cnt == '0) || (g_cnt == '0) || (b_cnt == '0) || (c_cnt == '0))
         res_nxt.meas_err = 1'b1;
      else if (c_cnt > DARK_THRESH)
         res_nxt.color = COL_NONE;
      else if ((r_cnt <= g_cnt) && (r_cnt <= b_cnt))
         res_nxt.color = COL_RED;
      else if (g_cnt <= b_cnt)
         res_nxt.color = COL_GREEN;
      else
         res_nxt.color = COL_BLUE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res.color    <= COL_NONE;
         res.meas_err <= 1'b0;
      end else if (state == ST_DECIDE) begin
         res <= res_nxt;
      end
   end

   assign bus.filter_sel = flt;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.done       = (state == ST_DONE);
   assign bus.color      = res.color;
   assign bus.meas_err   = res.meas_err;

endmodule

// File: tb/tb_sb_1237_color_sequencer.sv
// Random and directed scans against an argmin reference model of the colour sequencer.
module tb_sb_1237_color_sequencer;
   import sb_1237_color_sequencer_pkg::*;

   localparam int S     = 4;
   localparam int DARK  = 1000;
   localparam int SCAN  = 4 * (S + 1) + 2;

   logic clk;
   logic rst_n;
   logic [3:0][CNT_W-1:0] tbl;
   int   n_vec, n_err;

   sb_1237_color_sequencer_if bus();

   sb_1237_color_sequencer #(.SETTLE_CYCLES(S), .DARK_THRESH(14'd1000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // sensor model: pulse width follows the currently selected filter
   assign bus.count = tbl[bus.filter_sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // {meas_err, color[1:0]}: dead sample wins, then dark, then brightest channel (first wins ties)
   function automatic int ref_result(input int r, input int g, input int b, input int c);
      int v[3];
      int best;
      if (r == 0 || g == 0 || b == 0 || c == 0) return 4;
      if (c > DARK) return 0;
      v[0] = r; v[1] = g; v[2] = b;
      best = 0;
      for (int i = 1; i < 3; i++)
         if (v[i] < v[best]) best = i;
      return best + 1;
   endfunction

   // expected filter at scan-relative cycle n (1 = first SETTLE cycle)
   function automatic int exp_fsel(input int n);
      filter_e ord[4];
      ord[0] = FLT_RED; ord[1] = FLT_GREEN; ord[2] = FLT_BLUE; ord[3] = FLT_CLEAR;
      if (n >= 1 && n <= 4 * (S + 1)) return int'(ord[(n - 1) / (S + 1)]);
      return int'(FLT_CLEAR);
   endfunction

   task automatic set_counts(input int r, input int g, input int b, input int c);
      tbl[FLT_RED]   = CNT_W'(r);
      tbl[FLT_GREEN] = CNT_W'(g);
      tbl[FLT_BLUE]  = CNT_W'(b);
      tbl[FLT_CLEAR] = CNT_W'(c);
   endtask

   task automatic run_scan(input int r, input int g, input int b, input int c, input bit poke);
      int exp, n, bad_f, bad_b, extra;
      set_counts(r, g, b, c);
      exp = ref_result(r, g, b, c);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("first_busy", int'(bus.busy), 1);
      n = 1; bad_f = 0; bad_b = 0;
      while (!bus.done && n < SCAN + 10) begin
         if (int'(bus.filter_sel) != exp_fsel(n)) bad_f++;
         if (!bus.busy) bad_b++;
         bus.start = (poke && n == 8);
         tick();
         n++;
      end
      bus.start = 1'b0;
      chk("latency", n, SCAN);
      chk("fsel_seq", bad_f, 0);
      chk("busy_hold", bad_b, 0);
      chk("color", int'(bus.color), exp & 3);
      chk("meas_err", int'(bus.meas_err), exp >> 2);
      tick();
      chk("done_pulse", int'(bus.done), 0);
      chk("busy_drop", int'(bus.busy), 0);
      chk("color_held", int'(bus.color), exp & 3);
      if (poke) begin
         extra = 0;
         for (int k = 0; k < SCAN + 8; k++) begin
            if (bus.busy || bus.done) extra++;
            tick();
         end
         chk("no_requeue", extra, 0);
      end
   endtask

   task automatic run_continuous();
      int n, ndone, bad_f, bad_b;
      int dt[3];
      set_counts(200, 600, 700, 150);
      bus.continuous = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 1; ndone = 0; bad_f = 0; bad_b = 0;
      dt[0] = 0; dt[1] = 0; dt[2] = 0;
      while (n < 4 * SCAN) begin
         if (int'(bus.filter_sel) != exp_fsel(((n - 1) % SCAN) + 1)) bad_f++;
         if (!bus.busy) bad_b++;
         if (bus.done) begin
            dt[ndone] = n;
            ndone++;
            chk("cont_color", int'(bus.color), int'(COL_RED));
         end
         if (ndone == 3) break;
         if (ndone == 2 && n == dt[1] + 5) bus.continuous = 1'b0;
         tick();
         n++;
      end
      chk("cont_ndone", ndone, 3);
      chk("cont_first", dt[0], SCAN);
      chk("cont_gap1", dt[1] - dt[0], SCAN);
      chk("cont_gap2", dt[2] - dt[1], SCAN);
      chk("cont_fsel", bad_f, 0);
      chk("cont_busy", bad_b, 0);
      tick();
      chk("cont_stop", int'(bus.busy), 0);
   endtask

   task automatic run_reset_mid();
      int extra;
      set_counts(800, 700, 250, 120);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k < 12; k++) tick();
      chk("pre_rst_fsel", int'(bus.filter_sel), int'(FLT_BLUE));
      rst_n = 1'b0;
      #1;
      chk("rst_fsel", int'(bus.filter_sel), int'(FLT_CLEAR));
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_color", int'(bus.color), int'(COL_NONE));
      chk("rst_err", int'(bus.meas_err), 0);
      bus.start = 1'b1;
      tick(); tick();
      chk("rst_vs_start", int'(bus.busy), 0);
      bus.start = 1'b0;
      rst_n = 1'b1;
      extra = 0;
      for (int k = 0; k < SCAN + 8; k++) begin
         if (bus.busy || bus.done) extra++;
         tick();
      end
      chk("rst_no_done", extra, 0);
   endtask

   function automatic int rnd_cnt();
      if ($urandom_range(0, 24) == 0) return 0;
      if ($urandom_range(0, 9) == 0) return 16383;
      return int'($urandom_range(1, 1023));
   endfunction

   initial begin
      int r, g, b, c;
      n_vec = 0; n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.continuous = 1'b0;
      set_counts(1, 1, 1, 1);
      tick(); tick();
      chk("reset_fsel", int'(bus.filter_sel), int'(FLT_CLEAR));
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_color", int'(bus.color), int'(COL_NONE));
      chk("reset_err", int'(bus.meas_err), 0);
      rst_n = 1'b1;
      tick(); tick();

      run_scan(200, 600, 700, 150, 1'b0);
      run_scan(300, 300, 500, 100, 1'b1);
      run_scan(800, 700, 250, 120, 1'b0);
      run_scan(900, 900, 900, 1500, 1'b0);
      run_scan(400, 0, 300, 200, 1'b0);
      run_scan(500, 400, 400, 1000, 1'b0);
      run_scan(500, 400, 400, 1001, 1'b0);
      run_scan(16383, 16382, 16383, 1, 1'b0);

      run_continuous();
      run_reset_mid();

      for (int i = 0; i < 24; i++) begin
         r = rnd_cnt(); g = rnd_cnt(); b = rnd_cnt();
         c = int'($urandom_range(1, 1400));
         if ($urandom_range(0, 3) == 0) g = r;
         if ($urandom_range(0, 3) == 0) b = g;
         if ($urandom_range(0, 24) == 0) c = 0;
         run_scan(r, g, b, c, ($urandom_range(0, 4) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sb_1237_color_sequencer.md
SB_1237_COLOR_SEQUENCER -- requirements
Module: sb_1237_color_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 50000, meaning dwell cycles per filter before sampling (1 ms at 50 MHz).
REQ-002 SHALL have parameter DARK_THRESH, default 14'd1000, meaning clear-filter count above which the target is "no object".
REQ-003 Port clk  input  1  system clock, one clock domain.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request one RGB scan; sampled in IDLE only.
REQ-006 Port continuous  input  1  when 1, a new scan begins immediately after each DONE.
REQ-007 Port count  input  14  pulse-high width from the frequency counter; smaller value means higher intensity.
REQ-008 Port filter_sel  output  2  TCS3200 {S2,S3}: RED=00, BLUE=01, CLEAR=10, GREEN=11.
REQ-009 Port busy  output  1  high while a scan is in progress.
REQ-010 Port done  output  1  one-cycle pulse when the scan result is valid.
REQ-011 Port color  output  2  result: NONE=00, RED=01, GREEN=10, BLUE=11; held until the next done.
REQ-012 Port meas_err  output  1  high with done if any sampled count was 0; held like color.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE, DECIDE, DONE.
REQ-014 Filter order SHALL be RED, GREEN, BLUE, CLEAR; filter_sel SHALL be CLEAR in IDLE.
REQ-015 start=1 in IDLE (cycle 0) SHALL give SETTLE with filter_sel=RED and busy=1 at cycle 1.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then SAMPLE for 1 cycle, capturing count into that filter's 14-bit register.
REQ-017 After SAMPLE, filter_sel SHALL advance to the next filter and the FSM SHALL return to SETTLE; after the CLEAR sample it SHALL go to DECIDE.
REQ-018 DECIDE (1 cycle) SHALL register the result; done=1 SHALL occur at cycle 4*(SETTLE_CYCLES+1)+2 after start.
REQ-019 Result rules, in priority order:
- any sample==0 -> color=NONE, meas_err=1;
- clear > DARK_THRESH -> NONE;
- otherwise the minimum of red/green/blue.
REQ-020 Ties SHALL resolve RED over GREEN over BLUE.
REQ-021 Comparisons SHALL be unsigned 14-bit, with no scaling.
REQ-022 In DONE, continuous=1 SHALL go to SETTLE/RED next cycle with busy held 1; otherwise the FSM SHALL go to IDLE with busy=0 next cycle.
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 Deasserting continuous mid-scan SHALL let the current scan finish, then return to IDLE.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, filter_sel=CLEAR, busy=0, done=0, color=NONE, meas_err=0, sample registers=0 and settle counter=0.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no done pulse; reset SHALL win over a simultaneous start.

Structure
REQ-027 A shared package/header SHALL hold the filter_sel encodings, color encodings and FSM state encodings, reused by top-level and bench.
REQ-028 The settle timer SHALL be one sub-module, sb_1237_dwell_timer: load/enable, expire pulse, width ceil(log2(SETTLE_CYCLES+1)).

Verification (SETTLE_CYCLES=4, DARK_THRESH=1000; bench drives count per filter_sel)
REQ-029 Red dominant: counts R=200, G=600, B=700, C=150; start pulse -> done at cycle 22 after start, color=RED, meas_err=0.
REQ-030 Tie: R=G=300, B=500, C=100 -> color=RED. Blue dominant: R=800, G=700, B=250, C=120 -> color=BLUE.
REQ-031 Dark and error:
- C=1500, R=G=B=900 -> color=NONE, meas_err=0;
- G=0, others valid -> color=NONE, meas_err=1.
REQ-032 Continuous=1 over 3 scans -> done pulses 22 cycles apart, busy never drops, filter_sel sequence 00,11,01,10 repeating.
REQ-033 Reset mid-BLUE SETTLE -> outputs equal their reset values immediately, no done; start during busy -> no extra scan, single done.
